gpio_irq_ip: RTL
================

// Module: gpio_irq_ip
// PURPOSE
//  Parametrised GPIO peripheral on the core's simple valid/we memory bus: direction and data registers,
//  atomic SET/CLR/TGL writes, a synchronised pin read, and per-pin rise/fall edge interrupts.
//  Interrupt status is write-1-to-clear (W1C) and drives one level interrupt line to the core.
//  Register-compatible at 0x00/0x04/0x08 with the first-generation GPIO register block.
// PARAMETERS
//  GPIO_W       32  number of pins (1..32); register bits [31:GPIO_W] read 0, writes to them ignored
//  SYNC_STAGES  2   input synchroniser flops per pin (>=2)
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       asynchronous active-low reset
//  bus_valid  in   1       bus request strobe, one cycle per access
//  bus_we     in   1       1=write, 0=read
//  bus_addr   in   32      byte address; decode on bus_addr[7:2], other bits ignored
//  bus_wdata  in   32      write data
//  bus_rdata  out  32      read data, registered
//  gpio_in    in   GPIO_W  asynchronous pin inputs
//  gpio_out   out  GPIO_W  pin output value (DATA & DIR)
//  gpio_oe    out  GPIO_W  pin output enable (= DIR)
//  irq        out  1       interrupt, level, active-high
// BEHAVIOUR
//  Register map (offset, access, reset value):
//   0x00 DATA RW 0 | 0x04 DIR RW 0 (1=output) | 0x08 READ RO (DIR&DATA)|(~DIR&in_sync)
//   0x0C SET WO: DATA|=wdata | 0x10 CLR WO: DATA&=~wdata | 0x14 TGL WO: DATA^=wdata
//   0x18 IE RW 0 | 0x1C RISE_EN RW 0 | 0x20 FALL_EN RW 0 | 0x24 ISTAT RW1C 0
//   WO registers read 0; unmapped offsets (0x28..0xFC) read 0, writes ignored.
//  Write: on a clk edge with bus_valid&bus_we the target register updates; visible on outputs the next cycle.
//  Read: on a clk edge with bus_valid&~bus_we, bus_rdata loads the addressed value (1-cycle latency).
//   bus_rdata holds its value until the next read; no wait states, no error response.
//  Input path: gpio_in -> SYNC_STAGES flops -> in_sync -> one more flop in_prev; all reset to 0.
//  Edges: rise = in_sync&~in_prev, fall = ~in_sync&in_prev; evaluated only where DIR=0.
//   ISTAT[i] sets when (rise[i]&RISE_EN[i]) | (fall[i]&FALL_EN[i]); both enables = any edge.
//   Latency: pin change before edge E -> ISTAT bit visible SYNC_STAGES+1 cycles after E.
//  ISTAT W1C: write 1 clears a bit, write 0 has no effect. If a clear and a new event hit the same bit
//   in the same cycle, the set wins (bit stays 1). Edge detection never looks at IE.
//  irq = |(ISTAT & IE), computed from registers only (no path from gpio_in or the bus).
//  Narrow pulses shorter than a clk period may be missed; this is allowed (no pulse stretching).
//  Reset (async assert, any time incl. mid-access): all registers, sync flops, bus_rdata=0;
//   gpio_out=0, gpio_oe=0, irq=0. Any in-flight access is dropped.
//   Pins high when reset is released cause a rise after sync, but RISE_EN=0 at reset, so ISTAT stays 0.
//  Reserved/high bits: bits above GPIO_W are zero in every register and on every read.
// TESTING
//  1 Reset: after rst_n=0 mid-write, check bus_rdata, gpio_out, gpio_oe, irq = 0; every register reads 0.
//  2 DIR=0x0000FFFF, DATA=0xA5A55A5A, gpio_in=0xFFFF0000 -> gpio_out=0x00005A5A, READ=0xFFFF5A5A.
//  3 SET 0x000000F0, CLR 0x0000000A, TGL 0x00000101 on DATA=0x00005A5A -> DATA reads 0x00005BF1.
//  4 DIR=0, RISE_EN[3]=1, IE[3]=1, pin 3 0->1 -> ISTAT=0x8, irq=1 exactly SYNC_STAGES+1 cycles later;
//    write ISTAT=0x8 -> irq=0; falling pin 3 sets nothing.
//  5 Clear ISTAT[3] in the same cycle a new rise on pin 3 reaches it -> ISTAT[3] stays 1, irq stays 1.
//  6 GPIO_W=8: write 0xFFFFFFFF to DATA/DIR -> reads 0x000000FF; read offset 0x40 -> 0; irq unaffected.

Source files
------------

// File: rtl/gpio_irq_ip.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gpio_irq_ip                                                     |
// | Purpose  : GPIO block with atomic data updates and W1C edge interrupts.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module gpio_irq_ip #(
   parameter int GPIO_W      = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bus_valid,
   input  logic              bus_we,
   input  logic [31:0]       bus_addr,
   input  logic [31:0]       bus_wdata,
   output logic [31:0]       bus_rdata,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic [GPIO_W-1:0] gpio_out,
   output logic [GPIO_W-1:0] gpio_oe,
   output logic              irq
);

   localparam logic [5:0] c_IDX_DATA  = 6'd0;
   localparam logic [5:0] c_IDX_DIR   = 6'd1;
   localparam logic [5:0] c_IDX_READ  = 6'd2;
   localparam logic [5:0] c_IDX_SET   = 6'd3;
   localparam logic [5:0] c_IDX_CLR   = 6'd4;
   localparam logic [5:0] c_IDX_TGL   = 6'd5;
   localparam logic [5:0] c_IDX_IE    = 6'd6;
   localparam logic [5:0] c_IDX_RISE  = 6'd7;
   localparam logic [5:0] c_IDX_FALL  = 6'd8;
   localparam logic [5:0] c_IDX_ISTAT = 6'd9;

   logic [GPIO_W-1:0] r_data, r_dir, r_ie, r_rise_en, r_fall_en, r_istat;
   logic [GPIO_W-1:0] r_sync [SYNC_STAGES];
   logic [GPIO_W-1:0] r_prev, r_event;
   logic [31:0]       r_rdata;

   logic [5:0]        w_idx;
   logic              w_wr, w_rd;
   logic [GPIO_W-1:0] w_wdata, w_in_sync, w_rise, w_fall, w_event, w_pins, w_clr;
   logic [31:0]       w_rd_val;
   logic              w_unused_addr;

   assign w_idx     = bus_addr[7:2];
   assign w_wr      = bus_valid & bus_we;
   assign w_rd      = bus_valid & ~bus_we;
   assign w_wdata   = bus_wdata[GPIO_W-1:0];
   assign w_in_sync = r_sync[SYNC_STAGES-1];
   assign w_rise    = w_in_sync & ~r_prev;
   assign w_fall    = ~w_in_sync & r_prev;
   assign w_event   = ((w_rise & r_rise_en) | (w_fall & r_fall_en)) & ~r_dir;
   assign w_pins    = (r_dir & r_data) | (~r_dir & w_in_sync);
   assign w_clr     = (w_wr && (w_idx == c_IDX_ISTAT)) ? w_wdata : '0;

   assign w_unused_addr = ^{bus_addr[31:8], bus_addr[1:0]};

   generate
      if (GPIO_W < 32) begin : g_unused_hi
         logic w_unused_wdata_hi;
         assign w_unused_wdata_hi = ^bus_wdata[31:GPIO_W];
      end
   endgenerate

   // Edge events are registered once more so an interrupt lands SYNC_STAGES+1 cycles after the pin edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
         r_prev  <= '0;
         r_event <= '0;
      end else begin
         r_sync[0] <= gpio_in;
         for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
         r_prev  <= w_in_sync;
         r_event <= w_event;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data    <= '0;
         r_dir     <= '0;
         r_ie      <= '0;
         r_rise_en <= '0;
         r_fall_en <= '0;
      end else if (w_wr) begin
         case (w_idx)
            c_IDX_DATA: r_data    <= w_wdata;
            c_IDX_DIR:  r_dir     <= w_wdata;
            c_IDX_SET:  r_data    <= r_data | w_wdata;
            c_IDX_CLR:  r_data    <= r_data & ~w_wdata;
            c_IDX_TGL:  r_data    <= r_data ^ w_wdata;
            c_IDX_IE:   r_ie      <= w_wdata;
            c_IDX_RISE: r_rise_en <= w_wdata;
            c_IDX_FALL: r_fall_en <= w_wdata;
            default: ;
         endcase
      end
   end

   // A new event on the same bit overrides a simultaneous W1C clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_istat <= '0;
      else        r_istat <= (r_istat & ~w_clr) | r_event;
   end

   always_comb begin
      w_rd_val = '0;
      case (w_idx)
         c_IDX_DATA:  w_rd_val[GPIO_W-1:0] = r_data;
         c_IDX_DIR:   w_rd_val[GPIO_W-1:0] = r_dir;
         c_IDX_READ:  w_rd_val[GPIO_W-1:0] = w_pins;
         c_IDX_IE:    w_rd_val[GPIO_W-1:0] = r_ie;
         c_IDX_RISE:  w_rd_val[GPIO_W-1:0] = r_rise_en;
         c_IDX_FALL:  w_rd_val[GPIO_W-1:0] = r_fall_en;
         c_IDX_ISTAT: w_rd_val[GPIO_W-1:0] = r_istat;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    r_rdata <= '0;
      else if (w_rd) r_rdata <= w_rd_val;
   end

   assign bus_rdata = r_rdata;
   assign gpio_out  = r_data & r_dir;
   assign gpio_oe   = r_dir;
   assign irq       = |(r_istat & r_ie);

endmodule
`default_nettype wire
